// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream mux/demux family.
//   AXIS_DATA_WIDTH : default tdata width shared by mux and demux
//   state_e         : demux packet-routing state
//   clog2_min1      : index width helper that never returns 0
package axi_stream_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_stream_demux_if.sv
// Bus bundle for axi_stream_demux.
//   select, s_tdata/s_tvalid/s_tlast/s_tready : slave stream in
//   m_tdata/m_tvalid/m_tlast/m_tready         : NUM_STREAMS master lanes out
//   modport slave  : the demux side
//   modport master : the environment driving the slave stream and lane readies
interface axi_stream_demux_if
  import axi_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int unsigned NUM_STREAMS = 2,
  parameter int unsigned SEL_WIDTH   = clog2_min1(NUM_STREAMS)
);

  logic [SEL_WIDTH-1:0]              select;
  logic [DATA_WIDTH-1:0]             s_tdata;
  logic                              s_tvalid;
  logic                              s_tlast;
  logic                              s_tready;
  logic [NUM_STREAMS*DATA_WIDTH-1:0] m_tdata;
  logic [NUM_STREAMS-1:0]            m_tvalid;
  logic [NUM_STREAMS-1:0]            m_tlast;
  logic [NUM_STREAMS-1:0]            m_tready;

  modport slave (
    input  select, s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output select, s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/axi_stream_reg_slice.sv
// Single-entry output stage holding {valid, dest, data, last}.
//   aclk_i/aresetn_i : clock, async active-low reset
//   load_i           : capture dest_i/data_i/last_i this cycle
//   m_tready_i       : per-lane ready; the stage drains on m_tready_i[dest_o]
//   valid_o/dest_o/data_o/last_o : registered stage contents
//   free_o           : stage can accept a beat this cycle
module axi_stream_reg_slice
  import axi_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int unsigned NUM_STREAMS = 2,
  parameter int unsigned SEL_WIDTH   = clog2_min1(NUM_STREAMS)
) (
  input  logic                   aclk_i,
  input  logic                   aresetn_i,
  input  logic                   load_i,
  input  logic [SEL_WIDTH-1:0]   dest_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   last_i,
  input  logic [NUM_STREAMS-1:0] m_tready_i,
  output logic                   valid_o,
  output logic [SEL_WIDTH-1:0]   dest_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   last_o,
  output logic                   free_o
);

  logic                  valid_q, valid_d;
  logic [SEL_WIDTH-1:0]  dest_q, dest_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  // Free when empty or draining this cycle, so load and drain can coincide.
  assign free_o = !valid_q || m_tready_i[dest_q];

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      dest_d  = dest_i;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && m_tready_i[dest_q]) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      valid_q <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign dest_o  = dest_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/axi_stream_demux.sv
// Packet-aware AXI-Stream demultiplexer, 1-cycle latency, full throughput.
//   aclk, aresetn : clock, async active-low reset
//   bus (slave)   : select + slave stream in, NUM_STREAMS master lanes out
//   drop_count    : saturating count of packets discarded for bad select
// Destination is sampled on the first beat of a packet and held until tlast.
module axi_stream_demux
  import axi_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int unsigned NUM_STREAMS = 2,
  parameter int unsigned SEL_WIDTH   = clog2_min1(NUM_STREAMS),
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_stream_demux_if.slave    bus,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic [SEL_WIDTH:0] NUM_LIM = (SEL_WIDTH+1)'(NUM_STREAMS);

  state_e                state_q;
  logic [SEL_WIDTH-1:0]  lock_dest_q;
  logic [CNT_WIDTH-1:0]  drop_count_q;

  logic                  stage_free;
  logic                  accept;
  logic                  sel_ok;
  logic                  route_beat;
  logic [SEL_WIDTH-1:0]  beat_dest;
  logic                  out_valid;
  logic [SEL_WIDTH-1:0]  out_dest;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  assign sel_ok       = {1'b0, bus.select} < NUM_LIM;
  // Dropped beats never touch the stage, so DROP consumes regardless of it.
  assign bus.s_tready = (state_q == DROP) ? 1'b1 : stage_free;
  assign accept       = bus.s_tvalid && bus.s_tready;
  assign route_beat   = accept && ((state_q == ROUTE) || ((state_q == IDLE) && sel_ok));
  assign beat_dest    = (state_q == ROUTE) ? lock_dest_q : bus.select;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      lock_dest_q  <= '0;
      drop_count_q <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (sel_ok) begin
            lock_dest_q <= bus.select;
            if (!bus.s_tlast) state_q <= ROUTE;
          end else begin
            if (drop_count_q != '1) drop_count_q <= drop_count_q + CNT_WIDTH'(1);
            if (!bus.s_tlast) state_q <= DROP;
          end
        end
        ROUTE, DROP: begin
          if (bus.s_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drop_count = drop_count_q;

  axi_stream_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_STREAMS(NUM_STREAMS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_stage (
    .aclk_i    (aclk),
    .aresetn_i (aresetn),
    .load_i    (route_beat),
    .dest_i    (beat_dest),
    .data_i    (bus.s_tdata),
    .last_i    (bus.s_tlast),
    .m_tready_i(bus.m_tready),
    .valid_o   (out_valid),
    .dest_o    (out_dest),
    .data_o    (out_data),
    .last_o    (out_last),
    .free_o    (stage_free)
  );

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_lane
    assign bus.m_tvalid[g] = out_valid && (out_dest == SEL_WIDTH'(g));
    assign bus.m_tlast[g]  = out_last && (out_dest == SEL_WIDTH'(g));
    assign bus.m_tdata[g*DATA_WIDTH +: DATA_WIDTH] =
      (out_dest == SEL_WIDTH'(g)) ? out_data : '0;
  end

endmodule

// File: doc/axi_stream_demux.md
Name: axi_stream_demux

Overview:
- Packet-aware AXI-Stream demultiplexer: one slave stream in, NUM_STREAMS master streams out; the counterpart to the existing combinational stream mux.
- Destination is sampled from `select` on the first beat of each packet and locked until the `s_tlast` beat is accepted.
- A single registered output stage gives 1-cycle latency and full throughput.
- Out-of-range destinations cause the whole packet to be discarded and counted.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- NUM_STREAMS, 2, number of master outputs (>=2).
- SEL_WIDTH, $clog2(NUM_STREAMS) (min 1), width of `select`.
- CNT_WIDTH, 16, width of `drop_count`.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- select  input  SEL_WIDTH  destination index; sampled only on the first beat of a packet.
- s_tdata  input  DATA_WIDTH  slave data.
- s_tvalid  input  1  slave valid.
- s_tlast  input  1  slave end-of-packet.
- s_tready  output  1  slave ready.
- m_tdata  output  NUM_STREAMS*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_tvalid  output  NUM_STREAMS  per-lane valid.
- m_tlast  output  NUM_STREAMS  per-lane last.
- m_tready  input  NUM_STREAMS  per-lane ready.
- drop_count  output  CNT_WIDTH  packets discarded because of bad `select`; saturating.

Behaviour:
- Reset (aresetn low, async assert, sync-safe deassert):
  - state=IDLE, out_valid=0, out_dest=0, out_data=0, out_last=0, drop_count=0.
  - Hence m_tvalid=0, m_tlast=0, m_tdata=0.
  - s_tready follows its combinational equation (=1 while the stage is empty).
- Beat acceptance: beat accepted when s_tvalid && s_tready.
- Output stage:
  - One register holding {out_valid, out_dest, out_data, out_last}.
  - stage_free = !out_valid || m_tready[out_dest].
- s_tready:
  - ROUTE/IDLE: s_tready = stage_free (combinational path from m_tready allowed).
  - DROP: s_tready = 1.
- States:
  - IDLE, no packet open, on accepted beat:
    - select < NUM_STREAMS: load stage with dest=select. If !s_tlast go to ROUTE with lock_dest=select; else stay IDLE.
    - select >= NUM_STREAMS: beat discarded and drop_count incremented (saturate at all-ones). If !s_tlast go to DROP; else stay IDLE.
  - ROUTE: each accepted beat loads the stage with dest=lock_dest; `select` is ignored. Accepted beat with s_tlast returns to IDLE.
  - DROP: every beat is consumed and discarded with no output. Accepted beat with s_tlast returns to IDLE.
- Stage update:
  - Accepted routed beat: stage loads.
  - Else if out_valid && m_tready[out_dest]: out_valid clears.
  - Simultaneous drain and load in the same cycle is legal (back-to-back, no bubble), including a dest change at a packet boundary.
- Outputs:
  - m_tvalid[i] = out_valid && (out_dest==i).
  - m_tlast[i] = out_last && (out_dest==i).
  - m_tdata lane i = out_data when out_dest==i, else 0.
- Latency: beat accepted in cycle N appears on the master lane in cycle N+1.
- Throughput: 1 beat/cycle while the selected m_tready=1.
- AXI rules:
  - Once m_tvalid[i] asserts, data/last/dest stay stable until m_tready[i].
  - s_tready may fall without s_tvalid.
  - No output depends on s_tvalid combinationally except through acceptance.
- Boundaries:
  - Backpressure on one lane does not affect other lanes' valid; ingress stalls (single shared stage, head-of-line blocking by design).
  - Single-beat packets are handled entirely in IDLE.
  - NUM_STREAMS not a power of two: indices NUM_STREAMS..2^SEL_WIDTH-1 are dropped.
  - Reset mid-packet: in-flight beat lost; next accepted beat is treated as first beat of a new packet.

Decomposition:
- Package axi_stream_pkg:
  - state enum {IDLE, ROUTE, DROP} (2-bit).
  - Function clog2_min1.
  - Shared DATA_WIDTH default, for reuse by axi_stream_mux.
- Sub-module axi_stream_reg_slice (data+last+dest register with valid/ready) is natural for the output stage; FSM and drop counter stay in the top.

Test Plan:
- Routing: packet of 3 beats 0x11,0x22,0x33 (last on 0x33), select=1 on first beat then select=0 → lane1 gets 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after acceptance, m_tlast[1] on 0x33, lane0 m_tvalid never 1.
- Boundary switch: back-to-back single-beat packets 0xA0 to dest 0 and 0xB0 to dest 1, all ready high → lane0 valid cycle N+1, lane1 valid cycle N+2, no bubble, s_tready constant 1.
- Backpressure: m_tready[1]=0 for 4 cycles while streaming to lane 1 → s_tready=0 after first beat; lane1 data held at first beat value; resumes without loss or duplication when ready returns.
- Drop: NUM_STREAMS=3, select=3 with 4-beat packet → s_tready=1 all 4 beats, no m_tvalid, drop_count 0→1; following good packet routes normally.
- Saturation: CNT_WIDTH=2, 5 bad packets → drop_count 1,2,3,3,3.
- Async reset mid-packet: assert aresetn=0 between beats 2 and 3 of a ROUTE packet → m_tvalid=0 immediately, drop_count=0; next beat after release samples `select` as new packet.
